hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Parametrised successor to the pipeline's forwarding-only hazard unit. It sits beside the five-stage datapath and generates forwarding selects, load-use stalls, taken-branch flushes, and the interlocks for one non-pipelined multi-cycle execute unit (multiply/divide) of configurable latency. A registered scoreboard holds the multi-cycle op's pending destination and counts down its latency. It also arbitrates the single register-file write port between the normal writeback path and the multi-cycle result.

## Interface
- REG_ADDR_W, 5, register address width (2**REG_ADDR_W architectural registers; register 0 hard-wired zero)
- MC_LAT, 4, multi-cycle unit latency in cycles; legal range 1..255
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rs1D, rs2D, rdD  in  REG_ADDR_W each  source/destination registers of the instruction in Decode
- regwriteD, mc_opD  in  1 each  Decode instruction writes a register / is a multi-cycle op
- rs1E, rs2E, rdE  in  REG_ADDR_W each  Execute-stage sources and destination
- regwriteE, resultsrcE, mc_opE  in  1 each  Execute writes a register / is a load / is a multi-cycle op
- rdM, rdW  in  REG_ADDR_W each  Memory and Writeback destinations
- regwriteM, regwriteW  in  1 each  Memory and Writeback write enables
- pcsrcE  in  1  taken branch/jump resolved in Execute
- stallF, stallD  out  1 each  hold PC / hold the Fetch-Decode register
- flushD, flushE  out  1 each  bubble the Fetch-Decode / Decode-Execute register
- forwardA_selE, forwardB_selE  out  2 each  operand source: 00 register file, 01 Writeback result, 10 Memory ALU result
- mc_wb  out  1  multi-cycle result owns the register-file write port this cycle
- mc_rd  out  REG_ADDR_W  destination for mc_wb
- mc_busy  out  1  scoreboard holds a pending multi-cycle op

## Operation
- Forwarding, per operand: if regwriteM, rdM!=0 and rdM==rsXE, select 10. Otherwise, if regwriteW, rdW!=0 and rdW==rsXE, select 01. Otherwise select 00. Memory has priority over Writeback.
- Load-use hazard (lu): resultsrcE & regwriteE & rdE!=0 & (rdE==rs1D | rdE==rs2D).
- Multi-cycle RAW hazard (mr): pending register pend_rd!=0, and pend_rd matches rs1D or rs2D. A register is pending when mc_busy holds it, or when mc_opE holds it as rdE.
- WAW hazard (ww): regwriteD & mc_busy & rdD==pend_rd & pend_rd!=0.
- Structural hazard (st): mc_opD & (mc_busy | mc_opE).
- Stall condition: stall = (lu | mr | ww | st) & !pcsrcE. When stall is true, assert stallF, stallD and flushE.
- When pcsrcE is true, assert flushD and flushE. stallF and stallD are 0 so the PC loads the branch target. A taken branch overrides every stall.
- Scoreboard states are IDLE, COUNT and READY.
  - IDLE to COUNT on mc_opE & !pcsrcE: cnt <= MC_LAT-1, pend_rd <= rdE. With MC_LAT==1 the transition goes directly to READY.
  - COUNT decrements cnt each cycle and moves to READY when cnt reaches 0.
  - READY asserts mc_wb when regwriteW==0, then returns to IDLE at the next edge. If regwriteW==1 it stays in READY: normal writeback wins and the multi-cycle write defers.
- mc_busy = (state != IDLE). mc_rd = pend_rd. mc_rd is 0 in IDLE.

## Timing
- All stall, flush, forward and mc_wb outputs are combinational from the inputs and the registered scoreboard state. Zero-cycle latency.
- Reset, asynchronous: state IDLE, cnt 0, pend_rd 0. Resulting outputs: mc_busy 0, mc_wb 0, mc_rd 0. Stall, flush and forward outputs follow their inputs.
- mc_opE in cycle t gives mc_wb at the earliest in cycle t+MC_LAT. Each cycle with regwriteW high in READY delays mc_wb by one cycle.
- The RAW stall on pend_rd is released in the cycle after mc_wb, because the register-file read then sees the written value.
- Reset asserted mid-COUNT drops the pending op silently; no mc_wb is issued.
- mc_opE and pcsrcE high in the same cycle cannot occur, because one instruction cannot be both. The flushed-wrong-path guard is still required.

## Structure
- Package hazard_pkg holds:
  - forward-select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - scoreboard state enum {SB_IDLE, SB_COUNT, SB_READY}
- Sub-module mc_scoreboard holds the state, cnt (width $clog2(MC_LAT+1)) and pend_rd, and produces mc_busy, mc_wb and mc_rd.
- The top level keeps forwarding and stall/flush logic combinational.

## Test plan
- **Forwarding:** add x5 in M, add x5 in W, rs1E=5. Required: forwardA_selE=10. With regwriteM=0 it becomes 01. With rdM=rdW=0 it is 00.
- **Load-use:** lw x7 in E (resultsrcE=1), rs2D=7. Required: stallF=stallD=flushE=1 for exactly one cycle. The next cycle forwards 01.
- **Taken branch during load-use:** pcsrcE=1 with the lu condition true. Required: flushD=flushE=1, stallF=stallD=0.
- **Multi-cycle latency:** MC_LAT=4, mul x9 in E at cycle 0, an instruction reading x9 in D. Required: stall over cycles 1-4, mc_wb=1 and mc_rd=9 in cycle 4, stall released in cycle 5.
- **Write-port conflict:** READY with regwriteW=1 for 2 cycles. Required: mc_wb=0 for those 2 cycles and 1 in the third; mc_busy stays high throughout.
- **Structural, WAW and reset:** mul in D while mc_busy is high stalls. add writing pend_rd in D stalls. rst_n dropped mid-COUNT gives mc_busy=0 immediately and no mc_wb afterwards.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared forward-select encodings and scoreboard state type
// Revision : 1.0
// ============================================================================
package hazard_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      SB_IDLE  = 2'd0,
      SB_COUNT = 2'd1,
      SB_READY = 2'd2
   } sb_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_unit_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : mc_scoreboard
// Brief    : Tracks the one in-flight multi-cycle op and arbitrates its writeback
// Revision : 1.0
// ============================================================================
module mc_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int MC_LAT     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mc_opE,
   input  logic                  pcsrcE,
   input  logic [REG_ADDR_W-1:0] rdE,
   input  logic                  regwriteW,
   output logic                  mc_busy,
   output logic                  mc_wb,
   output logic [REG_ADDR_W-1:0] mc_rd
);

   localparam int              CNT_W    = $clog2(MC_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   sb_state_e              state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [REG_ADDR_W-1:0]  pend_rd_q, pend_rd_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SB_IDLE;
         cnt_q     <= '0;
         pend_rd_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_rd_q <= pend_rd_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_rd_d = pend_rd_q;
      mc_wb     = 1'b0;
      case (state_q)
         SB_IDLE: begin
            // A multi-cycle op on a flushed wrong path must never claim the unit
            if (mc_opE && !pcsrcE) begin
               pend_rd_d = rdE;
               if (MC_LAT == 1) begin
                  state_d = SB_READY;
                  cnt_d   = '0;
               end else begin
                  state_d = SB_COUNT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         SB_COUNT: begin
            if (cnt_q <= CNT_ONE) begin
               state_d = SB_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         SB_READY: begin
            // Normal writeback keeps the port; the multi-cycle result waits
            if (!regwriteW) begin
               mc_wb     = 1'b1;
               state_d   = SB_IDLE;
               pend_rd_d = '0;
            end
         end
         default: begin
            state_d   = SB_IDLE;
            cnt_d     = '0;
            pend_rd_d = '0;
         end
      endcase
   end

   assign mc_busy = (state_q != SB_IDLE);
   assign mc_rd   = pend_rd_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_unit
// Brief    : Forwarding, stall/flush and multi-cycle interlock control
// Revision : 1.0
// ============================================================================
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int MC_LAT     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] rs1D,
   input  logic [REG_ADDR_W-1:0] rs2D,
   input  logic [REG_ADDR_W-1:0] rdD,
   input  logic                  regwriteD,
   input  logic                  mc_opD,
   input  logic [REG_ADDR_W-1:0] rs1E,
   input  logic [REG_ADDR_W-1:0] rs2E,
   input  logic [REG_ADDR_W-1:0] rdE,
   input  logic                  regwriteE,
   input  logic                  resultsrcE,
   input  logic                  mc_opE,
   input  logic [REG_ADDR_W-1:0] rdM,
   input  logic [REG_ADDR_W-1:0] rdW,
   input  logic                  regwriteM,
   input  logic                  regwriteW,
   input  logic                  pcsrcE,
   output logic                  stallF,
   output logic                  stallD,
   output logic                  flushD,
   output logic                  flushE,
   output logic [1:0]            forwardA_selE,
   output logic [1:0]            forwardB_selE,
   output logic                  mc_wb,
   output logic [REG_ADDR_W-1:0] mc_rd,
   output logic                  mc_busy
);

   logic w_fwd_m_ok, w_fwd_w_ok;
   logic w_lu, w_mr, w_ww, w_st, w_stall;
   logic w_pend_busy, w_pend_exe;

   mc_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W),
      .MC_LAT     (MC_LAT)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .mc_opE    (mc_opE),
      .pcsrcE    (pcsrcE),
      .rdE       (rdE),
      .regwriteW (regwriteW),
      .mc_busy   (mc_busy),
      .mc_wb     (mc_wb),
      .mc_rd     (mc_rd)
   );

   assign w_fwd_m_ok = regwriteM && (rdM != '0);
   assign w_fwd_w_ok = regwriteW && (rdW != '0);

   always_comb begin
      forwardA_selE = FWD_REG;
      forwardB_selE = FWD_REG;
      if (w_fwd_m_ok && (rdM == rs1E))      forwardA_selE = FWD_MEM;
      else if (w_fwd_w_ok && (rdW == rs1E)) forwardA_selE = FWD_WB;
      if (w_fwd_m_ok && (rdM == rs2E))      forwardB_selE = FWD_MEM;
      else if (w_fwd_w_ok && (rdW == rs2E)) forwardB_selE = FWD_WB;
   end

   assign w_lu = resultsrcE && regwriteE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

   // The op still in Execute is pending one cycle before the scoreboard captures it
   assign w_pend_busy = mc_busy && (mc_rd != '0) && ((mc_rd == rs1D) || (mc_rd == rs2D));
   assign w_pend_exe  = mc_opE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
   assign w_mr        = w_pend_busy || w_pend_exe;

   assign w_ww    = regwriteD && mc_busy && (rdD == mc_rd) && (mc_rd != '0);
   assign w_st    = mc_opD && (mc_busy || mc_opE);
   assign w_stall = (w_lu || w_mr || w_ww || w_st) && !pcsrcE;

   assign stallF = w_stall;
   assign stallD = w_stall;
   assign flushD = pcsrcE;
   assign flushE = w_stall || pcsrcE;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl_unit
// Brief    : Directed-vector scoreboard bench for hazard_ctrl_unit
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl_unit;

   localparam int W   = 5;
   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] rs1D, rs2D, rdD, rs1E, rs2E, rdE, rdM, rdW;
   logic         regwriteD, mc_opD, regwriteE, resultsrcE, mc_opE;
   logic         regwriteM, regwriteW, pcsrcE;
   logic         stallF, stallD, flushD, flushE, mc_wb, mc_busy;
   logic [1:0]   forwardA_selE, forwardB_selE;
   logic [W-1:0] mc_rd;

   typedef struct {
      string       name;
      logic [14:0] v;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.REG_ADDR_W(W), .MC_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .regwriteD(regwriteD), .mc_opD(mc_opD),
      .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .regwriteE(regwriteE),
      .resultsrcE(resultsrcE), .mc_opE(mc_opE),
      .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
      .pcsrcE(pcsrcE),
      .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
      .forwardA_selE(forwardA_selE), .forwardB_selE(forwardB_selE),
      .mc_wb(mc_wb), .mc_rd(mc_rd), .mc_busy(mc_busy)
   );

   task automatic clr();
      rs1D = '0; rs2D = '0; rdD = '0; regwriteD = 0; mc_opD = 0;
      rs1E = '0; rs2E = '0; rdE = '0; regwriteE = 0; resultsrcE = 0; mc_opE = 0;
      rdM = '0; rdW = '0; regwriteM = 0; regwriteW = 0; pcsrcE = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      clr();
   endtask

   // Expected: stall (stallF=stallD), flushD, flushE, fwdA, fwdB, mc_wb, mc_rd, mc_busy
   task automatic expect_out(input string name, input logic st, input logic fd, input logic fe,
                             input logic [1:0] fa, input logic [1:0] fb,
                             input logic wb, input logic [W-1:0] rd, input logic busy);
      exp_t e;
      e.name = name;
      e.v    = {st, st, fd, fe, fa, fb, wb, rd, busy};
      exp_q.push_back(e);
   endtask

   // Monitor: compares one queued expectation per cycle, mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t        e;
         logic [14:0] act;
         e   = exp_q.pop_front();
         act = {stallF, stallD, flushD, flushE, forwardA_selE, forwardB_selE,
                mc_wb, mc_rd, mc_busy};
         checks++;
         if (act !== e.v) begin
            failures++;
            $display("FAIL %s: got sF=%b sD=%b fD=%b fE=%b fA=%b fB=%b wb=%b rd=%0d busy=%b, required sF=%b sD=%b fD=%b fE=%b fA=%b fB=%b wb=%b rd=%0d busy=%b",
                     e.name, act[14], act[13], act[12], act[11], act[10:9], act[8:7],
                     act[6], act[5:1], act[0], e.v[14], e.v[13], e.v[12], e.v[11],
                     e.v[10:9], e.v[8:7], e.v[6], e.v[5:1], e.v[0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      clr();

      next_cycle();
      expect_out("reset", 0, 0, 0, 2'b00, 2'b00, 0, 5'd0, 0);
      next_cycle(); rst_n = 1'b1;

      // Forwarding
      next_cycle();
      regwriteM = 1; rdM = 5; regwriteW = 1; rdW = 5; rs1E = 5; rs2E = 3;
      expect_out("fwd_mem_prio", 0, 0, 0, 2'b10, 2'b00, 0, 5'd0, 0);
      next_cycle();
      regwriteM = 0; rdM = 5; regwriteW = 1; rdW = 5; rs1E = 5;
      expect_out("fwd_wb", 0, 0, 0, 2'b01, 2'b00, 0, 5'd0, 0);
      next_cycle();
      regwriteM = 1; regwriteW = 1; rdM = 0; rdW = 0; rs1E = 0; rs2E = 0;
      expect_out("fwd_x0", 0, 0, 0, 2'b00, 2'b00, 0, 5'd0, 0);
      next_cycle();
      regwriteM = 1; rdM = 5; rs1E = 5; regwriteW = 1; rdW = 6; rs2E = 6;
      expect_out("fwd_both", 0, 0, 0, 2'b10, 2'b01, 0, 5'd0, 0);

      // Load-use
      next_cycle();
      resultsrcE = 1; regwriteE = 1; rdE = 7; rs2D = 7;
      expect_out("lu_stall", 1, 0, 1, 2'b00, 2'b00, 0, 5'd0, 0);
      next_cycle();
      regwriteM = 1; rdM = 7; rs2D = 7;
      expect_out("lu_released", 0, 0, 0, 2'b00, 2'b00, 0, 5'd0, 0);
      next_cycle();
      regwriteW = 1; rdW = 7; rs2E = 7;
      expect_out("lu_fwd_wb", 0, 0, 0, 2'b00, 2'b01, 0, 5'd0, 0);
      next_cycle();
      resultsrcE = 1; regwriteE = 1; rdE = 0; rs1D = 0;
      expect_out("lu_x0", 0, 0, 0, 2'b00, 2'b00, 0, 5'd0, 0);
      next_cycle();
      resultsrcE = 1; regwriteE = 1; rdE = 7; rs1D = 7; pcsrcE = 1;
      expect_out("branch_over_lu", 0, 1, 1, 2'b00, 2'b00, 0, 5'd0, 0);

      // Multi-cycle RAW: mul x9 at cycle 0, reader of x9 waiting in Decode
      next_cycle();
      mc_opE = 1; regwriteE = 1; rdE = 9; rs1D = 9;
      expect_out("mc_c0", 1, 0, 1, 2'b00, 2'b00, 0, 5'd0, 0);
      for (int c = 1; c <= 3; c++) begin
         next_cycle(); rs1D = 9;
         expect_out($sformatf("mc_c%0d", c), 1, 0, 1, 2'b00, 2'b00, 0, 5'd9, 1);
      end
      next_cycle(); rs1D = 9;
      expect_out("mc_c4_wb", 1, 0, 1, 2'b00, 2'b00, 1, 5'd9, 1);
      next_cycle(); rs1D = 9;
      expect_out("mc_c5_release", 0, 0, 0, 2'b00, 2'b00, 0, 5'd0, 0);

      // Write-port conflict, with structural and WAW checks while counting
      next_cycle();
      mc_opE = 1; regwriteE = 1; rdE = 12;
      expect_out("wp_c0", 0, 0, 0, 2'b00, 2'b00, 0, 5'd0, 0);
      next_cycle(); mc_opD = 1;
      expect_out("struct_stall", 1, 0, 1, 2'b00, 2'b00, 0, 5'd12, 1);
      next_cycle(); regwriteD = 1; rdD = 12;
      expect_out("waw_stall", 1, 0, 1, 2'b00, 2'b00, 0, 5'd12, 1);
      next_cycle(); regwriteD = 0; rdD = 12;
      expect_out("waw_no_write", 0, 0, 0, 2'b00, 2'b00, 0, 5'd12, 1);
      next_cycle(); regwriteW = 1; rdW = 3;
      expect_out("wp_defer1", 0, 0, 0, 2'b00, 2'b00, 0, 5'd12, 1);
      next_cycle(); regwriteW = 1; rdW = 3;
      expect_out("wp_defer2", 0, 0, 0, 2'b00, 2'b00, 0, 5'd12, 1);
      next_cycle();
      expect_out("wp_wb", 0, 0, 0, 2'b00, 2'b00, 1, 5'd12, 1);
      next_cycle();
      expect_out("wp_idle", 0, 0, 0, 2'b00, 2'b00, 0, 5'd0, 0);

      // Wrong-path multi-cycle op must not start the scoreboard
      next_cycle();
      mc_opE = 1; rdE = 4; rs1D = 4; pcsrcE = 1;
      expect_out("mc_branch", 0, 1, 1, 2'b00, 2'b00, 0, 5'd0, 0);
      next_cycle();
      expect_out("mc_branch_guard", 0, 0, 0, 2'b00, 2'b00, 0, 5'd0, 0);

      // Reset mid-COUNT drops the op
      next_cycle();
      mc_opE = 1; rdE = 10;
      expect_out("rst_c0", 0, 0, 0, 2'b00, 2'b00, 0, 5'd0, 0);
      next_cycle();
      expect_out("rst_c1", 0, 0, 0, 2'b00, 2'b00, 0, 5'd10, 1);
      next_cycle(); rst_n = 1'b0;
      expect_out("rst_async", 0, 0, 0, 2'b00, 2'b00, 0, 5'd0, 0);
      next_cycle(); rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         expect_out("rst_no_wb", 0, 0, 0, 2'b00, 2'b00, 0, 5'd0, 0);
      end

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
